pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Resolves load-use, control redirect, I-cache miss, D-cache miss and multi-cycle multiply hazards into one consistent set of per-stage stall/flush strobes.
- Guarantees that no pipeline register ever receives stall and flush in the same cycle, so stage-register priority never matters.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 4, total cycles a multiply occupies EX (legal range 2..15)
CNT_W, 4, width of the multiply down-counter (must hold MUL_LAT-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset: synchronous, active-low (sampled on the rising edge of clk)
id_rs1_addr  in  5  rs1 index of the instruction in ID
id_rs2_addr  in  5  rs2 index of the instruction in ID
ex_memread  in  1  instruction in EX is a load
ex_rd_addr  in  5  rd index of the instruction in EX
ex_mul  in  1  instruction in EX is a multi-cycle multiply
ex_redirect  in  1  branch/jump in EX resolved taken or mispredicted
icache_stall  in  1  I-cache miss pending
dcache_stall  in  1  D-cache miss pending
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF_ID
ifid_flush  out  1  clear IF_ID
idex_stall  out  1  hold ID_EX
idex_flush  out  1  clear ID_EX (insert bubble)
exmem_stall  out  1  hold EX_MEM
exmem_flush  out  1  clear EX_MEM (bubble behind stalled EX)
memwb_stall  out  1  hold MEM_WB
mul_busy  out  1  FSM in MUL state
mul_done  out  1  final EX cycle of a multiply
stall_cycles  out  32  count of cycles with pc_stall=1, saturating at 32'hFFFF_FFFF

Behaviour:
- State: FSM {RUN, MUL}, down-counter cnt[CNT_W], stall_cycles. All registered on posedge clk.
- Reset: when rst_n=0 at a clock edge, next state is RUN, cnt=0, stall_cycles=0.
- While rst_n=0, the combinational outputs are: ifid_flush=1, idex_flush=1, exmem_flush=1; every stall output, mul_busy and mul_done =0.
- A reset asserted mid-multiply aborts it: the next cycle is RUN.
- Strobe outputs are combinational from state and inputs, with zero latency. Evaluation uses strict priority, highest first.
- P1 dcache_stall=1:
  - pc, ifid, idex, exmem and memwb stalls =1; all flushes =0.
  - FSM and cnt freeze; mul_done is forced to 0.
  - stall_cycles increments.
- P2 MUL state, cnt>1:
  - pc, ifid and idex stalls =1; exmem_flush=1; memwb runs.
  - cnt decrements by 1.
- P2' MUL state, cnt==1:
  - mul_done=1; no stall or flush from the multiply; next state RUN.
  - Lower priorities P3..P6 are still evaluated in this cycle.
- P3 RUN with ex_mul=1:
  - Same strobes as P2.
  - cnt loads MUL_LAT-1; next state MUL.
  - Result: a multiply spends exactly MUL_LAT cycles in EX, and its last cycle is the mul_done cycle.
  - ex_mul is ignored while in MUL.
- P4 ex_redirect=1:
  - ifid_flush=1, idex_flush=1, pc_stall=0 (PC loads target).
  - Overrides load-use and icache_stall. The I-cache must accept the new fetch address.
- P5 load-use: ex_memread=1, ex_rd_addr!=0, and ex_rd_addr equals id_rs1_addr or id_rs2_addr.
  - pc_stall=1, ifid_stall=1, idex_flush=1. Exactly one bubble per hazard.
- P6 icache_stall=1: pc_stall=1, ifid_stall=1, idex_flush=1.
- Otherwise: all strobes are 0.
- Invariants (assertions):
  - ifid_stall and ifid_flush are never both 1; the same holds for idex_stall/idex_flush and exmem_stall/exmem_flush.
  - cnt==0 whenever the state is RUN.
- stall_cycles increments by 1 on every clock edge where pc_stall=1 and rst_n=1, and holds at all-ones.

Test Plan:
- Load-use: ex_memread=1, ex_rd_addr=5, id_rs1_addr=5 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only; stall_cycles 0->1. Repeat with ex_rd_addr=0 -> no strobes.
- Multiply, MUL_LAT=4: ex_mul=1 in RUN at cycle t -> stalls plus exmem_flush at t, t+1, t+2; mul_done=1 and no stall at t+3; RUN at t+4; stall_cycles=3.
- dcache_stall=1 for 2 cycles at t+1 during the multiply -> all five stalls =1 and cnt frozen; mul_done moves to t+5. Check no stall/flush pair is ever both 1.
- ex_redirect=1 together with icache_stall=1 and a load-use match -> ifid_flush=idex_flush=1, pc_stall=0, ifid_stall=0.
- rst_n=0 for 1 cycle at MUL cnt=2 -> all flushes =1 during reset; next cycle RUN, mul_busy=0, stall_cycles=0.
- Force stall_cycles near 32'hFFFF_FFFE, then hold icache_stall=1 for 3 cycles -> value reaches 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the pipeline, per-stage
// stall/flush strobes and status back to it.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        ex_memread;
    logic [4:0]  ex_rd_addr;
    logic        ex_mul;
    logic        ex_redirect;
    logic        icache_stall;
    logic        dcache_stall;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_stall;
    logic        idex_flush;
    logic        exmem_stall;
    logic        exmem_flush;
    logic        memwb_stall;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1_addr, id_rs2_addr, ex_memread, ex_rd_addr, ex_mul,
               ex_redirect, icache_stall, dcache_stall,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_stall, mul_busy, mul_done,
               stall_cycles
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, ex_memread, ex_rd_addr, ex_mul,
               ex_redirect, icache_stall, dcache_stall,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_stall, mul_busy, mul_done,
               stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised per-stage stall/flush strobes,
// multi-cycle multiply sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MUL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      stall_q;

    logic load_use;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, exmem_flush, memwb_stall, mul_done;

    assign load_use = hz.ex_memread && (hz.ex_rd_addr != 5'd0) &&
                      ((hz.ex_rd_addr == hz.id_rs1_addr) ||
                       (hz.ex_rd_addr == hz.id_rs2_addr));

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_stall = 1'b0;
        mul_done    = 1'b0;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hz.dcache_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_stall = 1'b1;
        end else if ((state == MUL && cnt > CNT_W'(1)) ||
                     (state == RUN && hz.ex_mul)) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            // Final multiply cycle releases EX, so lower-priority hazards still apply.
            mul_done = (state == MUL) && (cnt == CNT_W'(1));
            if (hz.ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use || hz.icache_stall) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            if (pc_stall && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (!hz.dcache_stall) begin
                case (state)
                    RUN: if (hz.ex_mul) begin
                        state <= MUL;
                        cnt   <= CNT_W'(MUL_LAT - 1);
                    end
                    MUL: if (cnt > CNT_W'(1)) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                    default: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(ifid_stall && ifid_flush));
            assert (!(idex_stall && idex_flush));
            assert (!(exmem_stall && exmem_flush));
            assert (state != RUN || cnt == '0);
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.ifid_stall   = ifid_stall;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_stall   = idex_stall;
    assign hz.idex_flush   = idex_flush;
    assign hz.exmem_stall  = exmem_stall;
    assign hz.exmem_flush  = exmem_flush;
    assign hz.memwb_stall  = memwb_stall;
    assign hz.mul_busy     = rst_n && (state == MUL);
    assign hz.mul_done     = mul_done;
    assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random stimulus,
// all checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_left;   // EX cycles still owed to the multiply after this one started
    logic [31:0] m_cnt;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Order: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, busy, done
    function automatic logic [9:0] model_strobes();
        logic lu;
        logic [9:0] v;
        v  = '0;
        lu = hz.ex_memread && hz.ex_rd_addr != 0 &&
             (hz.ex_rd_addr == hz.id_rs1_addr || hz.ex_rd_addr == hz.id_rs2_addr);
        if (!rst_n)
            v = 10'b0010101000;
        else if (hz.dcache_stall)
            v = {10'b1101010100} | {8'b0, m_left > 0, 1'b0};
        else if (m_left > 1 || (m_left == 0 && hz.ex_mul))
            v = {10'b1101001000} | {8'b0, m_left > 0, 1'b0};
        else begin
            v[1] = (m_left > 0);
            v[0] = (m_left == 1);
            if (hz.ex_redirect)                 v[9:2] = 8'b00101000;
            else if (lu || hz.icache_stall)     v[9:2] = 8'b11001000;
        end
        return v;
    endfunction

    function automatic logic [9:0] dut_strobes();
        return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                hz.idex_flush, hz.exmem_stall, hz.exmem_flush, hz.memwb_stall,
                hz.mul_busy, hz.mul_done};
    endfunction

    // Inputs already applied; check at negedge, advance model, cross posedge.
    task automatic cyc(input string tag);
        logic [9:0] e;
        @(negedge clk);
        e = model_strobes();
        chk({tag, ".strobes"}, {22'b0, dut_strobes()}, {22'b0, e});
        chk({tag, ".stall_cycles"}, hz.stall_cycles, m_cnt);
        if (!rst_n) begin
            m_left = 0;
            m_cnt  = 0;
        end else begin
            if (e[9]) m_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
            if (!hz.dcache_stall) begin
                if (m_left > 0)     m_left--;
                else if (hz.ex_mul) m_left = MUL_LAT - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs1_addr  = 5'd1;
        hz.id_rs2_addr  = 5'd2;
        hz.ex_memread   = 1'b0;
        hz.ex_rd_addr   = 5'd0;
        hz.ex_mul       = 1'b0;
        hz.ex_redirect  = 1'b0;
        hz.icache_stall = 1'b0;
        hz.dcache_stall = 1'b0;
    endtask

    initial begin
        m_left = 0;
        m_cnt  = 0;
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset");
        rst_n = 1'b1;
        cyc("idle");

        // Load-use, then same pattern with rd=x0
        hz.ex_memread = 1'b1; hz.ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd5;
        cyc("load_use");
        idle(); cyc("after_lu");
        hz.ex_memread = 1'b1; hz.ex_rd_addr = 5'd0; hz.id_rs1_addr = 5'd0;
        cyc("lu_x0");
        idle();

        // Plain multiply
        hz.ex_mul = 1'b1;
        for (int i = 0; i < 5; i++) cyc("mul");
        idle(); cyc("mul_end");

        // Multiply with a 2-cycle D-cache miss at t+1
        hz.ex_mul = 1'b1; cyc("mul_d0");
        hz.dcache_stall = 1'b1; cyc("mul_d1"); cyc("mul_d2");
        hz.dcache_stall = 1'b0;
        for (int i = 0; i < 4; i++) cyc("mul_d");
        idle(); cyc("mul_d_end");

        // Redirect beats icache miss and load-use
        hz.ex_redirect = 1'b1; hz.icache_stall = 1'b1;
        hz.ex_memread = 1'b1; hz.ex_rd_addr = 5'd7; hz.id_rs2_addr = 5'd7;
        cyc("redirect");
        idle();

        // Reset mid-multiply at cnt==2
        hz.ex_mul = 1'b1; cyc("mulr0"); cyc("mulr1");
        rst_n = 1'b0; cyc("mulr_rst");
        rst_n = 1'b1; hz.ex_mul = 1'b0; cyc("mulr_after");

        // Counter saturation
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        m_cnt = 32'hFFFF_FFFE;
        hz.icache_stall = 1'b1;
        for (int i = 0; i < 4; i++) cyc("sat");
        idle();
        rst_n = 1'b0; cyc("rst2");
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            rst_n           = ($urandom_range(0, 59) != 0);
            hz.id_rs1_addr  = 5'($urandom_range(0, 7));
            hz.id_rs2_addr  = 5'($urandom_range(0, 7));
            hz.ex_memread   = ($urandom_range(0, 2) == 0);
            hz.ex_rd_addr   = 5'($urandom_range(0, 7));
            hz.ex_mul       = ($urandom_range(0, 5) == 0);
            hz.ex_redirect  = ($urandom_range(0, 6) == 0);
            hz.icache_stall = ($urandom_range(0, 4) == 0);
            hz.dcache_stall = ($urandom_range(0, 6) == 0);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
